// File: rtl/systolic_ctrl.sv
// Tile sequencer for an N-lane bit-serial systolic array: fetches K activation/weight
// vectors from a 1-cycle-latency buffer and streams each one for `precision` bit-cycles.
module systolic_ctrl #(
  parameter int ACT_WIDTH = 16,
  parameter int N         = 2,
  parameter int K_MAX     = 16,
  parameter int DONE_TMO  = 64,
  localparam int AW       = (K_MAX > 1) ? $clog2(K_MAX) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [AW:0]            cfg_k_i,
  input  logic [3:0]             cfg_precision_i,
  input  logic [4:0]             cfg_exp_i,
  output logic                   act_rd_en_o,
  output logic [AW-1:0]          act_rd_addr_o,
  input  logic [N*ACT_WIDTH-1:0] act_rd_data_i,
  input  logic [N*8-1:0]         wgt_rd_data_i,
  output logic                   arr_active_o,
  output logic [N*ACT_WIDTH-1:0] arr_act_o,
  output logic [N-1:0]           arr_w_o,
  output logic [3:0]             arr_precision_o,
  output logic [4:0]             arr_exp_set_o,
  input  logic                   arr_done_i,
  output logic                   busy_o,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic                   err_o
);

  localparam int KW = AW + 1;
  localparam int TW = $clog2(DONE_TMO + 1);
  localparam int DW = N * ACT_WIDTH;
  localparam int WW = N * 8;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_RESULT = 3'd4;

  localparam logic [KW-1:0] K_MAX_V  = KW'(K_MAX);
  localparam logic [KW-1:0] K_ONE    = KW'(1);
  localparam logic [TW-1:0] TMO_LAST = TW'(DONE_TMO - 1);

  logic [2:0]    state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [3:0]    prec_q, prec_d;
  logic [4:0]    exp_q, exp_d;
  logic [KW-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [KW-1:0] vec_cnt_q, vec_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [DW-1:0] act_q, act_d;
  logic [WW-1:0] wsr_q, wsr_d;
  logic [DW-1:0] stage_act_q;
  logic [WW-1:0] stage_wgt_q;
  logic          rd_valid_q;
  logic          err_q, err_d;

  logic          cfg_legal;
  logic          rd_en;
  logic          last_bit;
  logic          last_vec;
  logic [DW-1:0] load_act;
  logic [WW-1:0] load_wgt;
  logic [WW-1:0] wsr_shift;

  assign cfg_legal = (cfg_k_i != '0) && (cfg_k_i <= K_MAX_V) &&
                     (cfg_precision_i != 4'd0) && (cfg_precision_i <= 4'd8);
  assign last_bit  = (bit_cnt_q == prec_q - 4'd1);
  assign last_vec  = (vec_cnt_q == k_q - K_ONE);

  // Data read in the previous cycle is taken straight from the bus; otherwise from staging.
  assign load_act = rd_valid_q ? act_rd_data_i : stage_act_q;
  assign load_wgt = rd_valid_q ? wgt_rd_data_i : stage_wgt_q;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      assign wsr_shift[gi*8 +: 8] = {1'b0, wsr_q[gi*8+1 +: 7]};
      assign arr_w_o[gi]          = wsr_q[gi*8];
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    prec_d    = prec_q;
    exp_d     = exp_q;
    rd_ptr_d  = rd_ptr_q;
    bit_cnt_d = bit_cnt_q;
    vec_cnt_d = vec_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    act_d     = act_q;
    wsr_d     = wsr_q;
    err_d     = 1'b0;
    rd_en     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (cfg_legal) begin
            rd_en    = 1'b1;
            k_d      = cfg_k_i;
            prec_d   = cfg_precision_i;
            exp_d    = cfg_exp_i;
            rd_ptr_d = K_ONE;
            state_d  = S_FETCH;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_FETCH: begin
        rd_en = (rd_ptr_q < k_q);
        if (rd_en) rd_ptr_d = rd_ptr_q + K_ONE;
        act_d     = load_act;
        wsr_d     = load_wgt;
        bit_cnt_d = '0;
        vec_cnt_d = '0;
        state_d   = S_STREAM;
      end
      S_STREAM: begin
        if (last_bit) begin
          bit_cnt_d = '0;
          if (last_vec) begin
            act_d     = '0;
            wsr_d     = '0;
            rd_ptr_d  = '0;
            tmo_cnt_d = '0;
            state_d   = S_DRAIN;
          end else begin
            // Prefetch one vector ahead while the next one is loaded.
            rd_en = (rd_ptr_q < k_q);
            if (rd_en) rd_ptr_d = rd_ptr_q + K_ONE;
            act_d     = load_act;
            wsr_d     = load_wgt;
            vec_cnt_d = vec_cnt_q + K_ONE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          wsr_d     = wsr_shift;
        end
      end
      S_DRAIN: begin
        if (arr_done_i) begin
          state_d = S_RESULT;
        end else if (tmo_cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      S_RESULT: begin
        if (res_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      prec_q      <= '0;
      exp_q       <= '0;
      rd_ptr_q    <= '0;
      bit_cnt_q   <= '0;
      vec_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      act_q       <= '0;
      wsr_q       <= '0;
      stage_act_q <= '0;
      stage_wgt_q <= '0;
      rd_valid_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      prec_q     <= prec_d;
      exp_q      <= exp_d;
      rd_ptr_q   <= rd_ptr_d;
      bit_cnt_q  <= bit_cnt_d;
      vec_cnt_q  <= vec_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      act_q      <= act_d;
      wsr_q      <= wsr_d;
      rd_valid_q <= rd_en;
      err_q      <= err_d;
      if (rd_valid_q) begin
        stage_act_q <= act_rd_data_i;
        stage_wgt_q <= wgt_rd_data_i;
      end
    end
  end

  assign act_rd_en_o     = rd_en;
  assign act_rd_addr_o   = rd_en ? rd_ptr_q[AW-1:0] : '0;
  assign busy_o          = (state_q != S_IDLE);
  assign res_valid_o     = (state_q == S_RESULT);
  assign arr_active_o    = (state_q == S_STREAM);
  assign arr_act_o       = act_q;
  assign arr_precision_o = busy_o ? prec_q : 4'd0;
  assign arr_exp_set_o   = busy_o ? exp_q : 5'd0;
  assign err_o           = err_q;

endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 SHALL have parameter ACT_WIDTH, default 16, width of one FP16 activation lane.
REQ-002 SHALL have parameter N, default 2, array dimension (lanes).
REQ-003 SHALL have parameter K_MAX, default 16, max vectors per tile; AW = clog2(K_MAX).
REQ-004 SHALL have parameter DONE_TMO, default 64, cycles allowed for arr_done after streaming.
REQ-005 SHALL use one clock; reset is asynchronous and active-low: clk  in  1  clock; rst  in  1  async active-low reset.
REQ-006 start  in  1  begin tile (sampled in IDLE only).
REQ-007 cfg_k  in  AW+1  vectors in tile, legal 1..K_MAX.
REQ-008 cfg_precision  in  4  weight bits per vector, legal 1..8.
REQ-009 cfg_exp  in  5  shared exponent for array.
REQ-010 act_rd_en  out  1 / act_rd_addr  out  AW  buffer read; data returns next cycle.
REQ-011 act_rd_data  in  N*ACT_WIDTH  activation vector; wgt_rd_data  in  N*8  weight byte per lane, same address/latency.
REQ-012 arr_active  out  1 / arr_act  out  N*ACT_WIDTH / arr_w  out  N / arr_precision  out  4 / arr_exp_set  out  5  array drive.
REQ-013 arr_done  in  1  array accumulation complete (level).
REQ-014 busy  out  1 / res_valid  out  1 / res_ready  in  1 / err  out  1  (err one-cycle pulse).

Function
REQ-015 SHALL implement FSM IDLE -> FETCH -> STREAM -> DRAIN -> RESULT -> IDLE.
REQ-016 IDLE + start + legal cfg: latch cfg_k/cfg_precision/cfg_exp, act_rd_en=1 addr 0, go FETCH next cycle; busy=1 from FETCH until return to IDLE.
REQ-017 IDLE + start + illegal cfg (cfg_k=0 or >K_MAX, cfg_precision=0 or >8): err=1 for one cycle, stay IDLE, no read issued.
REQ-018 start outside IDLE SHALL be ignored; cfg inputs SHALL not affect an in-progress tile.
REQ-019 FETCH (1 cycle): load arr_act and per-lane weight shift regs from read data; issue read addr 1 if cfg_k>1; go STREAM.
REQ-020 STREAM: arr_active=1 continuously for exactly cfg_k*cfg_precision cycles, no bubbles.
REQ-021 Each vector SHALL be held on arr_act for cfg_precision cycles; arr_w[r] = bit b of lane r weight byte in bit-cycle b, LSB first (b=0..precision-1).
REQ-022 Next vector read SHALL issue in the cycle a vector is loaded; returned data captured in a staging register; when precision=1 the load SHALL bypass directly from read data.
REQ-023 act_rd_addr SHALL increment 0..cfg_k-1 exactly once each; no read beyond cfg_k-1.
REQ-024 arr_precision and arr_exp_set SHALL equal latched cfg while busy, 0 in IDLE.
REQ-025 After final bit-cycle: arr_active=0, arr_act=0, arr_w=0, go DRAIN.
REQ-026 DRAIN: on arr_done=1 go RESULT; if DONE_TMO cycles elapse without arr_done, pulse err, go IDLE without res_valid.
REQ-027 RESULT: res_valid=1 held until res_valid&&res_ready; then IDLE next cycle (busy=0).
REQ-028 res_ready asserted in RESULT entry cycle SHALL complete transfer that cycle (res_valid high exactly one cycle).

Reset
REQ-029 rst=0 SHALL asynchronously force IDLE; busy, res_valid, err, act_rd_en, act_rd_addr, arr_active, arr_act, arr_w, arr_precision, arr_exp_set, all counters and staging regs = 0.
REQ-030 rst asserted mid-tile SHALL abort; after release block SHALL accept a new start normally.

Verification
REQ-031 cfg_k=3, precision=4, exp=15, buffer {3C00,4000},{4200,4000},{0000,3C00}, weights 8'h0F all lanes -> reads addr 0,1,2; arr_active high 12 cycles; arr_act changes every 4 cycles; arr_w=2'b11 every cycle; arr_exp_set=15.
REQ-032 cfg_k=4, precision=1 -> arr_active 4 cycles, arr_act new vector every cycle, no bubble, 4 reads.
REQ-033 cfg_k=0, then cfg_precision=9 with start -> err one cycle each, busy stays 0, act_rd_en never 1.
REQ-034 arr_done held 0 -> err pulse exactly DONE_TMO cycles after DRAIN entry, then IDLE, res_valid never 1.
REQ-035 arr_done=1, res_ready low 5 cycles -> res_valid held 5+ cycles; start pulses during busy ignored; IDLE one cycle after handshake.
REQ-036 rst=0 in 3rd STREAM cycle -> all outputs 0 immediately; after release, fresh cfg_k=2 tile completes correctly.
